// File: rtl/divider_pkg.sv
// Shared types and constants for the divider reconstruction path.
package divider_pkg;

   localparam int DIV_W = 8;

   function automatic int cnt_width(input int w);
      if (w > 1) begin
         return $clog2(w);
      end else begin
         return 1;
      end
   endfunction

   localparam int CNT_W = cnt_width(DIV_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } recon_state_e;

endpackage

// File: rtl/divider_recon_mul_shift_add.sv
// Shift-and-add datapath: acc/mcand/mplier registers with load and single-step controls.
module recon_shift_add
   import divider_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_load,
   input  logic           i_step,
   input  logic [W-1:0]   i_mcand,
   input  logic [W-1:0]   i_mplier,
   input  logic [W-1:0]   i_addend,
   output logic [2*W-1:0] o_acc
);

   logic [2*W-1:0] r_acc;
   logic [2*W-1:0] r_mcand;
   logic [W-1:0]   r_mplier;

   // Operand capture and one multiplier bit per step; acc cannot overflow 2W bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= {(2*W){1'b0}};
         r_mcand  <= {(2*W){1'b0}};
         r_mplier <= {W{1'b0}};
      end else if (i_load) begin
         r_acc    <= {{W{1'b0}}, i_addend};
         r_mcand  <= {{W{1'b0}}, i_mcand};
         r_mplier <= i_mplier;
      end else if (i_step) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end else begin
            r_acc <= r_acc;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end else begin
         r_acc    <= r_acc;
         r_mcand  <= r_mcand;
         r_mplier <= r_mplier;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/divider_recon_mul.sv
// Rebuilds dividend = quotient*divisor + remainder and flags remainder >= divisor.
// Optional RECON_COMPARE_EN adds exp_dividend input and match output.
module divider_recon_mul
   import divider_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   quotient,
   input  logic [W-1:0]   divisor,
   input  logic [W-1:0]   remainder,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           rem_err
`ifdef RECON_COMPARE_EN
   ,
   input  logic [W-1:0]   exp_dividend,
   output logic           match
`endif
);

   localparam int CW = cnt_width(W);

   recon_state_e   r_state;
   recon_state_e   w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic           w_load;
   logic           w_step;
   logic           w_last;
   logic [2*W-1:0] w_acc;
   logic           r_busy;
   logic           r_done;
   logic           r_rem_err;
   logic [2*W-1:0] r_result;

   assign w_last = (r_cnt == CW'(W - 1));

   recon_shift_add #(.W(W)) u_shift_add (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_mcand  (divisor),
      .i_mplier (quotient),
      .i_addend (remainder),
      .o_acc    (w_acc)
   );

   // Next-state and datapath control decode.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = RUN;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, iteration counter and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= {CW{1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rem_err <= 1'b0;
         r_result  <= {(2*W){1'b0}};
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_cnt <= {CW{1'b0}};
         end else if (w_step) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            r_cnt <= r_cnt;
         end
         // Busy stays up through the done cycle, which already sits in IDLE.
         if (r_state == IDLE) begin
            r_busy <= start;
         end else begin
            r_busy <= 1'b1;
         end
         if (w_load) begin
            r_rem_err <= (remainder >= divisor);
         end else begin
            r_rem_err <= r_rem_err;
         end
         r_done <= (r_state == DONE);
         if (r_state == DONE) begin
            r_result <= w_acc;
         end else begin
            r_result <= r_result;
         end
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign result  = r_result;
   assign rem_err = r_rem_err;

`ifdef RECON_COMPARE_EN
   logic [W-1:0] r_exp_q;
   logic         r_match;

   // Expected dividend capture and end-of-run compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exp_q <= {W{1'b0}};
         r_match <= 1'b0;
      end else begin
         if (w_load) begin
            r_exp_q <= exp_dividend;
         end else begin
            r_exp_q <= r_exp_q;
         end
         if (r_state == DONE) begin
            r_match <= (w_acc[2*W-1:W] == {W{1'b0}}) && (w_acc[W-1:0] == r_exp_q) && !r_rem_err;
         end else begin
            r_match <= r_match;
         end
      end
   end

   assign match = r_match;
`endif

endmodule

// File: doc/divider_recon_mul.md
# divider_recon_mul

Sequential reconstruction unit sitting at the output end of the unsigned divider. It takes a quotient, a divisor and a remainder and rebuilds the dividend as `quotient*divisor + remainder` with an iterative shift-and-add multiplier. It also flags illegal remainders. It is used as the inverse path for on-chip self-check of divider results and as a standalone 8x8 multiply-accumulate.

## Interface
Parameters:
- `W`, default 8: operand width. The result width is `2*W`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `quotient`  in  W  multiplier operand.
- `divisor`  in  W  multiplicand operand.
- `remainder`  in  W  addend.
- `busy`  out  1  high while a computation is in progress.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  2W  reconstructed dividend, zero-extended.
- `rem_err`  out  1  high when the captured `remainder >= divisor`.
- `exp_dividend`  in  W  expected dividend. Present only with `RECON_COMPARE_EN`.
- `match`  out  1  comparison result. Present only with `RECON_COMPARE_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When `start`=1, capture the operands.
  - `acc <= {0, remainder}`, `mcand <= {0, divisor}`, `mplier <= quotient`, `cnt <= 0`.
  - `rem_err <= (remainder >= divisor)`. Because of this rule, `divisor`=0 always sets `rem_err`.
  - Go to RUN.
- RUN, each cycle:
  - If `mplier[0]`, then `acc <= acc + mcand`.
  - `mcand <= mcand << 1`, `mplier <= mplier >> 1`, `cnt++`.
  - After W iterations (`cnt == W-1`), go to DONE.
- DONE, for one cycle:
  - `result <= acc`, `done`=1.
  - Go to IDLE.
- Arithmetic:
  - All operations are unsigned.
  - `acc` is 2W bits wide. The maximum value is `(2^W-1)^2 + 2^W-1 = 2^2W - 2^W`, so `acc` never overflows and no carry-out is needed.
- Operand changes after capture have no effect.
- `start` while `busy` is ignored; it is not queued.
- `result` and `rem_err` hold their values until the next DONE, or the next capture for `rem_err`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `result`=0, `rem_err`=0, `match`=0. Internal registers are 0.
- Let edge k be the edge where `start`=1 is sampled in IDLE:
  - `busy`=1 from after edge k through the cycle in which `done`=1.
  - RUN occupies edges k+1 .. k+W.
  - `done`=1 and `result` is valid in the cycle after edge k+W+1. For W=8 that is 9 edges after start.
- `start` held high continuously launches a new operation on the first IDLE cycle after DONE. The throughput is one result per W+2 cycles.
- `rst` asserted at any point, including mid-RUN, returns all outputs to reset values on the next edge. A partial result is never presented.
- `rem_err` updates at capture (edge k), before `done`.

## Configuration
- Macro: `RECON_COMPARE_EN`.
- Defined:
  - Adds the `exp_dividend` input and the `match` output.
  - `exp_dividend` is captured with the other operands at `start`.
  - On the DONE edge: `match <= (acc[2W-1:W]==0) && (acc[W-1:0]==exp_dividend_q) && !rem_err`.
  - `match` holds until the next DONE and is cleared by reset.
- Undefined: the port and the output are absent, and no compare logic is built.

## Structure
- Shared package `divider_pkg`:
  - state enum (`IDLE`, `RUN`, `DONE`).
  - default width constant `DIV_W = 8`.
  - counter width `$clog2(DIV_W)`.
- One natural sub-module: `recon_shift_add`. It holds the `acc`/`mcand`/`mplier` registers and the single-step add/shift datapath, with `load` and `step` controls. The FSM, counter and flags stay in the top.

## Test plan
- `quotient`=14, `divisor`=7, `remainder`=2 -> `result`=100, `rem_err`=0, `done` 9 cycles after start. With the macro on, `exp_dividend`=100 gives `match`=1.
- `quotient`=13, `divisor`=15, `remainder`=5 -> `result`=200. Then `quotient`=85, `divisor`=3, `remainder`=0 -> `result`=255, `rem_err`=0.
- `quotient`=255, `divisor`=255, `remainder`=255 -> `result`=65280, with no wrap. With the macro on, `exp_dividend`=0 gives `match`=0.
- `quotient`=3, `divisor`=4, `remainder`=4 -> `result`=16, `rem_err`=1. Then `divisor`=0, `quotient`=9, `remainder`=0 -> `result`=0, `rem_err`=1.
- Pulse `start` again at cycle 3 of RUN with different operands -> ignored. The first result is delivered unchanged and exactly one `done` pulse occurs.
- Assert `rst` for 1 cycle at cycle 4 of RUN -> next cycle `busy`=0, `result`=0, `done` never pulses. A fresh start then computes 100/7 correctly (`result`=100).
